drawline: RTL and testbench
===========================

Name:
drawline

Overview:
- Bresenham line rasteriser for the 160x120, 3-bit-colour VGA framebuffer path.
- Given endpoints (x0,y0), (x1,y1) and a colour, it emits one pixel-write per clock on the vga_* plot interface, covering every pixel of the line in all octants.
- Signals completion with a level done flag under a start/done four-phase handshake.
- Sits between a drawing controller/FSM and the VGA adapter's plot port.

Parameters:
- none (screen fixed at 160 columns x 120 rows)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; held high by requester until done seen
- colour  input  3  line colour
- x0  input  8  start column
- y0  input  7  start row
- x1  input  8  end column
- y1  input  7  end row
- done  output  1  line complete; high until start drops
- vga_x  output  8  pixel column
- vga_y  output  7  pixel row
- vga_colour  output  3  pixel colour
- vga_plot  output  1  write strobe; vga_x/vga_y/vga_colour valid when high

Behaviour:
- Reset (async, rst_n=0): state IDLE, done=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0. Reset mid-line aborts immediately; no further plots until a new start.
- States: IDLE -> INIT -> DRAW -> DONE -> IDLE.
- IDLE:
  - done=0, vga_plot=0.
  - On clock with start=1: latch x0,y0,x1,y1,colour; go INIT.
  - Inputs may change after latching without effect.
- INIT (1 cycle):
  - dx=|x1-x0|, sx=+1 if x0<x1 else -1.
  - dy=-|y1-y0|, sy=+1 if y0<y1 else -1.
  - err=dx+dy; x=x0, y=y0.
  - Go DRAW.
- DRAW: each cycle:
  - vga_plot=1 with vga_x=x, vga_y=y, vga_colour=latched colour.
  - If x==x1 and y==y1: go DONE.
  - Otherwise, with e2=2*err:
    - if e2>=dy: err+=dy, x+=sx
    - if e2<=dx: err+=dx, y+=sy
    - both conditions may apply in the same cycle; err accumulates both terms.
- Arithmetic:
  - err, e2, dx, dy are signed 11-bit minimum; no overflow for any 8/7-bit endpoints.
  - x/y stepping uses signed add on 9/8-bit intermediates.
- Pixel count is exactly max(|x1-x0|,|y1-y0|)+1, both endpoints included, one pixel per cycle, no gaps, no duplicates.
- Clipping: if vga_x>=160 or vga_y>=120, suppress vga_plot for that pixel; the walk continues normally.
- Latency: first vga_plot 2 cycles after start is sampled; done asserted the cycle after the last plot.
- DONE:
  - done=1, vga_plot=0.
  - Stays until start=0, then go IDLE with done=0 on the next edge.
  - start held high while in DONE never retriggers.
- vga_plot is 0 in every state other than DRAW.
- Degenerate line (x0==x1, y0==y1): exactly one plot, then DONE.
- Horizontal, vertical and 45-degree lines are handled by the same algorithm with no special cases.

Test Plan:
- Reset: rst_n=0 with start=1 -> done=0, vga_plot=0. Release rst_n -> line begins; reset asserted mid-DRAW -> plotting stops at once.
- (59,20)->(50,25), colour 2:
  - 10 plots; first four are (59,20),(58,21),(57,21),(56,22); last is (50,25); all vga_colour=2.
  - Then done=1, held until start=0, then done=0.
- Mirrors: (59,25)->(50,20), (50,20)->(59,25), (50,25)->(59,20) -> 10 plots each, correct endpoints, monotonic x and y in the directions given by sx and sy.
- Steep line (10,5)->(12,100) -> 96 plots, y steps by exactly 1 every cycle. Horizontal (0,0)->(159,0) -> 160 plots. Single point (7,7)->(7,7) -> 1 plot.
- Handshake: keep start=1 for 50 cycles after done -> no extra plots. Change x0..colour during DRAW -> output line unchanged.
- Clipping: (150,110)->(200,127) -> vga_plot never high with vga_x>=160 or vga_y>=120; done still asserted after the full 51-step walk.

Source files
------------

// File: rtl/drawline.sv
// Bresenham line rasteriser for the 160x120 3-bit-colour VGA plot port.
// Emits one registered pixel write per clock; done is level, four-phase with start.
module drawline (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] colour,
    input  logic [7:0] x0,
    input  logic [6:0] y0,
    input  logic [7:0] x1,
    input  logic [6:0] y1,
    output logic       done,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        DRAW,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [7:0] x0_q, x0_d, x1_q, x1_d;
    logic [6:0] y0_q, y0_d, y1_q, y1_d;
    logic [2:0] col_q, col_d;

    logic signed [11:0] dx_q, dx_d;
    logic signed [11:0] dy_q, dy_d;
    logic signed [11:0] err_q, err_d;
    logic               sx_neg_q, sx_neg_d;
    logic               sy_neg_q, sy_neg_d;
    logic signed [8:0]  x_q, x_d;
    logic signed [7:0]  y_q, y_d;

    logic       done_q, done_d;
    logic       plot_q, plot_d;
    logic [7:0] vga_x_q, vga_x_d;
    logic [6:0] vga_y_q, vga_y_d;
    logic [2:0] vga_col_q, vga_col_d;

    logic signed [11:0] xdiff, ydiff, adx, ady, e2;
    logic               at_end, on_screen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            x0_q      <= '0;
            x1_q      <= '0;
            y0_q      <= '0;
            y1_q      <= '0;
            col_q     <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            err_q     <= '0;
            sx_neg_q  <= 1'b0;
            sy_neg_q  <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            done_q    <= 1'b0;
            plot_q    <= 1'b0;
            vga_x_q   <= '0;
            vga_y_q   <= '0;
            vga_col_q <= '0;
        end else begin
            state_q   <= state_d;
            x0_q      <= x0_d;
            x1_q      <= x1_d;
            y0_q      <= y0_d;
            y1_q      <= y1_d;
            col_q     <= col_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            err_q     <= err_d;
            sx_neg_q  <= sx_neg_d;
            sy_neg_q  <= sy_neg_d;
            x_q       <= x_d;
            y_q       <= y_d;
            done_q    <= done_d;
            plot_q    <= plot_d;
            vga_x_q   <= vga_x_d;
            vga_y_q   <= vga_y_d;
            vga_col_q <= vga_col_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        x0_d      = x0_q;
        x1_d      = x1_q;
        y0_d      = y0_q;
        y1_d      = y1_q;
        col_d     = col_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        err_d     = err_q;
        sx_neg_d  = sx_neg_q;
        sy_neg_d  = sy_neg_q;
        x_d       = x_q;
        y_d       = y_q;
        plot_d    = 1'b0;
        vga_x_d   = vga_x_q;
        vga_y_d   = vga_y_q;
        vga_col_d = vga_col_q;

        // Deltas are widened to 12 bits so 2*err never overflows.
        xdiff     = $signed({4'b0, x1_q}) - $signed({4'b0, x0_q});
        ydiff     = $signed({5'b0, y1_q}) - $signed({5'b0, y0_q});
        adx       = xdiff[11] ? -xdiff : xdiff;
        ady       = ydiff[11] ? -ydiff : ydiff;
        e2        = err_q <<< 1;
        at_end    = (x_q == $signed({1'b0, x1_q}))
                 && (y_q == $signed({1'b0, y1_q}));
        on_screen = (x_q[7:0] < 8'd160) && (y_q[6:0] < 7'd120);

        done_d    = (state_q == DONE) && start;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    x0_d    = x0;
                    y0_d    = y0;
                    x1_d    = x1;
                    y1_d    = y1;
                    col_d   = colour;
                    state_d = INIT;
                end
            end
            INIT: begin
                dx_d     = adx;
                dy_d     = -ady;
                err_d    = adx - ady;
                sx_neg_d = !(x0_q < x1_q);
                sy_neg_d = !(y0_q < y1_q);
                x_d      = $signed({1'b0, x0_q});
                y_d      = $signed({1'b0, y0_q});
                state_d  = DRAW;
            end
            DRAW: begin
                plot_d    = on_screen;
                vga_x_d   = x_q[7:0];
                vga_y_d   = y_q[6:0];
                vga_col_d = col_q;
                if (at_end) begin
                    state_d = DONE;
                end else begin
                    if (e2 >= dy_q) begin
                        err_d = err_d + dy_q;
                        x_d   = x_q + (sx_neg_q ? -9'sd1 : 9'sd1);
                    end
                    if (e2 <= dx_q) begin
                        err_d = err_d + dx_q;
                        y_d   = y_q + (sy_neg_q ? -8'sd1 : 8'sd1);
                    end
                end
            end
            DONE: begin
                if (!start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign done       = done_q;
    assign vga_plot   = plot_q;
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_col_q;

endmodule

// File: tb/tb_drawline.sv
// Directed bench for drawline: vector table of lines plus reset corner cases.
module tb_drawline;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] colour = '0;
    logic [7:0] x0 = '0, x1 = '0;
    logic [6:0] y0 = '0, y1 = '0;
    logic       done, vga_plot;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;

    int checks = 0;
    int errors = 0;

    drawline dut (
        .clk(clk), .rst_n(rst_n), .start(start), .colour(colour),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .done(done),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_plot(vga_plot)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] x0;
        logic [6:0] y0;
        logic [7:0] x1;
        logic [6:0] y1;
        logic [2:0] col;
        int         n;
        int         vis;
        int         fx, fy, lx, ly;
        int         hold;
        bit         mutate;
    } vec_t;

    vec_t tv[10];

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    function automatic int sgn(input int a);
        return (a > 0) ? 1 : ((a < 0) ? -1 : 0);
    endfunction

    function automatic int iabs(input int a);
        return (a < 0) ? -a : a;
    endfunction

    task automatic run_vec(input int idx);
        vec_t v;
        int cyc, first_cyc, got_done, bad_clip, bad_col, bad_step;
        int dirx, diry, ddx, ddy, xmaj, extra, lost;
        int px[$];
        int py[$];
        v = tv[idx];
        x0 = v.x0; y0 = v.y0; x1 = v.x1; y1 = v.y1; colour = v.col;
        start = 1'b1;
        cyc = 0; first_cyc = -1; got_done = 0;
        bad_clip = 0; bad_col = 0; bad_step = 0;
        while (!got_done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (v.mutate && cyc == 5) begin
                x0 = 8'd0; y0 = 7'd0; x1 = 8'd100; y1 = 7'd100;
                colour = ~v.col;
            end
            if (vga_plot) begin
                if (first_cyc < 0) first_cyc = cyc;
                px.push_back(int'(vga_x));
                py.push_back(int'(vga_y));
                if (vga_x >= 8'd160 || vga_y >= 7'd120) bad_clip++;
                if (vga_colour != v.col) bad_col++;
            end
            if (done) got_done = 1;
        end
        $display("vector %0d: %0d plots in %0d cycles", idx, px.size(), cyc);
        chk("done_seen", got_done, 1);
        chk("done_latency", cyc, v.n + 3);
        chk("first_plot_cycle", first_cyc, 3);
        chk("plot_count", px.size(), v.vis);
        if (px.size() > 0) begin
            chk("first_x", px[0], v.fx);
            chk("first_y", py[0], v.fy);
            chk("last_x", px[px.size()-1], v.lx);
            chk("last_y", py[py.size()-1], v.ly);
        end
        dirx = sgn(int'(v.x1) - int'(v.x0));
        diry = sgn(int'(v.y1) - int'(v.y0));
        xmaj = iabs(int'(v.x1) - int'(v.x0)) >= iabs(int'(v.y1) - int'(v.y0));
        for (int i = 1; i < px.size(); i++) begin
            ddx = px[i] - px[i-1];
            ddy = py[i] - py[i-1];
            if (ddx != 0 && ddx != dirx) bad_step++;
            if (ddy != 0 && ddy != diry) bad_step++;
            if (xmaj && ddx == 0) bad_step++;
            if (!xmaj && ddy == 0) bad_step++;
        end
        chk("clip_violations", bad_clip, 0);
        chk("colour_errors", bad_col, 0);
        chk("step_errors", bad_step, 0);
        extra = 0; lost = 0;
        for (int i = 0; i < v.hold; i++) begin
            @(negedge clk);
            if (vga_plot) extra++;
            if (!done) lost++;
        end
        if (v.hold > 0) begin
            chk("plots_while_held", extra, 0);
            chk("done_dropped_while_held", lost, 0);
        end
        start = 1'b0;
        @(negedge clk);
        chk("done_after_release", int'(done), 0);
        @(negedge clk);
        chk("plot_idle", int'(vga_plot), 0);
    endtask

    initial begin
        int seen, waited;
        //        x0   y0   x1   y1  col  n    vis  fx   fy   lx   ly  hold mut
        tv[0] = '{59,  20,  50,  25, 2,  10,  10,  59,  20,  50,  25, 50, 0};
        tv[1] = '{59,  25,  50,  20, 3,  10,  10,  59,  25,  50,  20, 0,  0};
        tv[2] = '{50,  20,  59,  25, 4,  10,  10,  50,  20,  59,  25, 0,  1};
        tv[3] = '{50,  25,  59,  20, 5,  10,  10,  50,  25,  59,  20, 0,  0};
        tv[4] = '{10,   5,  12, 100, 6,  96,  96,  10,   5,  12, 100, 0,  0};
        tv[5] = '{0,    0, 159,   0, 7, 160, 160,   0,   0, 159,   0, 0,  0};
        tv[6] = '{7,    7,   7,   7, 1,   1,   1,   7,   7,   7,   7, 3,  0};
        tv[7] = '{150, 110, 200, 127, 3, 51,  10, 150, 110, 159, 113, 0,  0};
        tv[8] = '{0,  119, 159,   0, 2, 160, 160,   0, 119, 159,   0, 0,  0};
        tv[9] = '{20,  30,  40,  50, 5,  21,  21,  20,  30,  40,  50, 0,  0};

        // Reset held with start high: nothing may happen.
        x0 = 8'd59; y0 = 7'd20; x1 = 8'd50; y1 = 7'd25; colour = 3'd2;
        start = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_done", int'(done), 0);
        chk("rst_plot", int'(vga_plot), 0);
        chk("rst_vga_x", int'(vga_x), 0);
        chk("rst_vga_y", int'(vga_y), 0);
        chk("rst_vga_colour", int'(vga_colour), 0);

        // Release: line starts from the held request.
        rst_n = 1'b1;
        seen = 0; waited = 0;
        while (!seen && waited < 10) begin
            @(negedge clk);
            waited++;
            if (vga_plot) seen = 1;
        end
        chk("post_rst_plot_seen", seen, 1);
        chk("post_rst_first_x", int'(vga_x), 59);
        chk("post_rst_first_y", int'(vga_y), 20);
        repeat (2) @(negedge clk);
        chk("mid_draw_plotting", int'(vga_plot), 1);

        // Asynchronous abort mid-line.
        @(posedge clk);
        #2 rst_n = 1'b0;
        start = 1'b0;
        #1 chk("abort_plot_immediate", int'(vga_plot), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (vga_plot || done) seen++;
        end
        chk("no_activity_after_abort", seen, 0);

        for (int i = 0; i < 10; i++) run_vec(i);

        // Exact opening pixels of the reference line.
        x0 = 8'd59; y0 = 7'd20; x1 = 8'd50; y1 = 7'd25; colour = 3'd2;
        start = 1'b1;
        begin
            int ex[4];
            int ey[4];
            int k, guard;
            ex = '{59, 58, 57, 56};
            ey = '{20, 21, 21, 22};
            k = 0; guard = 0;
            while (k < 4 && guard < 20) begin
                @(negedge clk);
                guard++;
                if (vga_plot) begin
                    chk("seq_x", int'(vga_x), ex[k]);
                    chk("seq_y", int'(vga_y), ey[k]);
                    k++;
                end
            end
            chk("seq_count", k, 4);
            guard = 0;
            while (!done && guard < 40) begin
                @(negedge clk);
                guard++;
            end
            chk("seq_done", int'(done), 1);
        end
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("seq_done_cleared", int'(done), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
